matrix_bram_arbiter: RTL and testbench

- Shares the single matrix BRAM between two requesters: req 0 is the compute datapath, req 1 is the input/display path.
- Each requester asks for a burst of read or write beats at a base address. The block arbitrates round-robin and sequences the BRAM ports (read port with 1-cycle latency, write port A).
- It streams read data back with per-beat valid/index and signals burst completion.

---
 rtl/matrix_bram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_matrix_bram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_bram_arbiter.sv
// Round-robin arbiter sharing the matrix BRAM between the compute datapath (requester 0)
// and the input/display path (requester 1). Requesters ask for read or write bursts.
// Reads use a 1-cycle-latency read port. Writes use port A.
module matrix_bram_arbiter #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       abort,
  input  logic [1:0]                 req,
  input  logic [1:0]                 req_wr,
  input  logic [2*ADDR_WIDTH-1:0]    req_base,
  input  logic [15:0]                req_len,
  input  logic [2*ELEMENT_WIDTH-1:0] wr_data,
  input  logic [1:0]                 wr_valid,
  output logic [1:0]                 wr_ready,
  output logic [1:0]                 gnt,
  output logic                       busy,
  output logic [1:0]                 rd_valid,
  output logic [ELEMENT_WIDTH-1:0]   rd_data,
  output logic [7:0]                 rd_index,
  output logic [1:0]                 done,
  output logic                       mem_rd_en,
  output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0]   mem_rd_data,
  output logic                       mem_a_we,
  output logic [ADDR_WIDTH-1:0]      mem_a_addr,
  output logic [ELEMENT_WIDTH-1:0]   mem_a_din
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN, S_FINISH} state_e;

  // The burst descriptor is captured at grant. Later changes on the request bus are ignored.
  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] base;
    logic [7:0]            len;
  } burst_t;

  state_e                   state_q, state_d;
  logic [1:0]               gnt_q, gnt_d;
  logic                     last_q, last_d;   // index of the requester served most recently
  burst_t                   bst_q, bst_d, req_bst;
  logic [7:0]               idx_q, idx_d;
  logic                     we_q, we_d;
  logic [ADDR_WIDTH-1:0]    a_addr_q, a_addr_d;
  logic [ELEMENT_WIDTH-1:0] a_din_q, a_din_d;
  logic [1:0]               rd_valid_q, rd_valid_d;
  logic [7:0]               rd_index_q, rd_index_d;

  logic                     sel;
  logic                     in_burst;
  logic                     last_beat;
  logic                     wr_acc;
  logic [ADDR_WIDTH-1:0]    beat_addr;
  logic [ELEMENT_WIDTH-1:0] wr_beat;

  // Select the winner. On a tie, the requester not served last wins. Then mux its descriptor.
  always_comb begin
    sel = (req == 2'b11) ? ~last_q : req[1];
    req_bst.wr   = sel ? req_wr[1] : req_wr[0];
    req_bst.base = sel ? req_base[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_base[ADDR_WIDTH-1:0];
    req_bst.len  = sel ? req_len[15:8] : req_len[7:0];
  end

  // Beat address generation and the write-handshake qualification.
  // A write beat offered in an abort cycle is not accepted, because that beat is dropped.
  always_comb begin
    in_burst  = (state_q == S_BURST);
    beat_addr = bst_q.base + ADDR_WIDTH'(idx_q);
    last_beat = (idx_q == bst_q.len - 8'd1);
    wr_ready  = (in_burst && bst_q.wr && !abort) ? (gnt_q & wr_valid) : 2'b00;
    wr_acc    = |wr_ready;
    wr_beat   = gnt_q[1] ? wr_data[2*ELEMENT_WIDTH-1:ELEMENT_WIDTH] : wr_data[ELEMENT_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Abort overrides every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (|req) state_d = (req_bst.len == 8'd0) ? S_FINISH : S_BURST;
      S_BURST: begin
        if (!bst_q.wr) begin
          if (last_beat) state_d = S_DRAIN;
        end else if (wr_acc && last_beat) begin
          state_d = S_FINISH;
        end
      end
      S_DRAIN:  state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // FSM outputs. A read issue is combinational in BURST, and its data returns on the next cycle.
  always_comb begin
    busy        = (state_q != S_IDLE);
    mem_rd_en   = in_burst && !bst_q.wr;
    mem_rd_addr = mem_rd_en ? beat_addr : '0;
    done        = (state_q == S_FINISH && !abort) ? gnt_q : 2'b00;
    gnt         = gnt_q;
    rd_valid    = rd_valid_q;
    rd_index    = rd_index_q;
    rd_data     = (|rd_valid_q) ? mem_rd_data : '0;
    mem_a_we    = we_q;
    mem_a_addr  = a_addr_q;
    mem_a_din   = a_din_q;
  end

  // Datapath next state: grant capture, beat counter, registered write port, read-return tagging.
  always_comb begin
    gnt_d      = gnt_q;
    last_d     = last_q;
    bst_d      = bst_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    a_addr_d   = a_addr_q;
    a_din_d    = a_din_q;
    rd_valid_d = mem_rd_en ? gnt_q : 2'b00;
    rd_index_d = mem_rd_en ? idx_q : rd_index_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d  = sel ? 2'b10 : 2'b01;
          last_d = sel;
          bst_d  = req_bst;
          idx_d  = 8'd0;
        end
      end
      S_BURST: begin
        if (mem_rd_en) idx_d = idx_q + 8'd1;
        if (wr_acc) begin
          we_d     = 1'b1;
          a_addr_d = beat_addr;
          a_din_d  = wr_beat;
          idx_d    = idx_q + 8'd1;
        end
      end
      S_FINISH: gnt_d = 2'b00;
      default: ;
    endcase
    // An abort in IDLE suppresses the grant, so last_served remains unchanged.
    if (abort) begin
      gnt_d  = 2'b00;
      we_d   = 1'b0;
      idx_d  = 8'd0;
      last_d = last_q;
      bst_d  = bst_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= 2'b00;
      last_q     <= 1'b1;
      bst_q      <= '0;
      idx_q      <= 8'd0;
      we_q       <= 1'b0;
      a_addr_q   <= '0;
      a_din_q    <= '0;
      rd_valid_q <= 2'b00;
      rd_index_q <= 8'd0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      bst_q      <= bst_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      a_addr_q   <= a_addr_d;
      a_din_q    <= a_din_d;
      rd_valid_q <= rd_valid_d;
      rd_index_q <= rd_index_d;
    end
  end

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// Directed bench for matrix_bram_arbiter, with a behavioural BRAM model.
// Inputs change at the falling edge. Outputs are sampled 1 time unit later.
module tb_matrix_bram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic [1:0]  req, req_wr, wr_valid;
  logic [19:0] req_base;
  logic [15:0] req_len, wr_data;
  logic [1:0]  wr_ready, gnt, rd_valid, done;
  logic        busy, mem_rd_en, mem_a_we;
  logic [7:0]  rd_data, rd_index, mem_rd_data, mem_a_din;
  logic [9:0]  mem_rd_addr, mem_a_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0] bram [0:1023];

  matrix_bram_arbiter #(.ELEMENT_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .req(req), .req_wr(req_wr),
    .req_base(req_base), .req_len(req_len), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .gnt(gnt), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_index(rd_index), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_a_we(mem_a_we), .mem_a_addr(mem_a_addr),
    .mem_a_din(mem_a_din)
  );

  always #5 clk = ~clk;

  // BRAM model. The preload is reapplied while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) bram[i] <= 8'h00;
      bram[10'h010] <= 8'd5;  bram[10'h011] <= 8'd6;
      bram[10'h012] <= 8'd7;  bram[10'h013] <= 8'd8;
      bram[10'h020] <= 8'h55; bram[10'h021] <= 8'h66;
      bram[10'h3FE] <= 8'h11; bram[10'h3FF] <= 8'h22;
      bram[10'h000] <= 8'h33; bram[10'h001] <= 8'h44;
      mem_rd_data   <= 8'h00;
    end else begin
      if (mem_a_we)  bram[mem_a_addr] <= mem_a_din;
      if (mem_rd_en) mem_rd_data <= bram[mem_rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, ".we"}, 32'(mem_a_we), 32'd0);
  endtask

  logic [7:0] wexp [3];
  logic [9:0] wrap_a [4];
  logic [7:0] wrap_d [4];

  initial begin
    wexp   = '{8'hA1, 8'hA2, 8'hA3};
    wrap_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    wrap_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0; abort = 1'b0; req = 2'b00; req_wr = 2'b00; wr_valid = 2'b00;
    req_base = '0; req_len = '0; wr_data = '0;

    // Reset values.
    tick(); #1;
    chk_quiet("rst");
    chk("rst.rd_valid", 32'(rd_valid), 0);
    chk("rst.rd_data", 32'(rd_data), 0);
    chk("rst.rd_index", 32'(rd_index), 0);
    chk("rst.wr_ready", 32'(wr_ready), 0);
    chk("rst.a_addr", 32'(mem_a_addr), 0);
    tick(); rst_n = 1'b1;

    // Read: requester 0, base 0x010, length 4.
    tick(); req = 2'b01; req_base[9:0] = 10'h010; req_len[7:0] = 8'd4; #1;
    chk("rd.idle_busy", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      tick(); if (k == 0) req = 2'b00; #1;
      chk("rd.gnt", 32'(gnt), 32'd1);
      chk("rd.en", 32'(mem_rd_en), 32'd1);
      chk("rd.addr", 32'(mem_rd_addr), 32'h010 + 32'(k));
      if (k > 0) begin
        chk("rd.valid", 32'(rd_valid), 32'd1);
        chk("rd.data", 32'(rd_data), 32'd5 + 32'(k - 1));
        chk("rd.index", 32'(rd_index), 32'(k - 1));
      end
      chk("rd.done_early", 32'(done), 0);
    end
    tick(); #1;
    chk("rd.drain_en", 32'(mem_rd_en), 0);
    chk("rd.drain_valid", 32'(rd_valid), 32'd1);
    chk("rd.drain_data", 32'(rd_data), 32'd8);
    chk("rd.drain_index", 32'(rd_index), 32'd3);
    chk("rd.drain_gnt", 32'(gnt), 32'd1);
    tick(); #1;
    chk("rd.done", 32'(done), 32'd1);
    chk("rd.fin_valid", 32'(rd_valid), 0);
    tick(); #1;
    chk_quiet("rd.after");

    // Write: requester 1, base 0x020, length 3, with a stall on the 2nd cycle.
    tick(); req = 2'b10; req_wr = 2'b10; req_base[19:10] = 10'h020; req_len[15:8] = 8'd3;
    wr_valid = 2'b10; wr_data[15:8] = 8'hA1; #1;
    chk("wr.idle_ready", 32'(wr_ready), 0);
    tick(); #1;
    chk("wr.c1_ready", 32'(wr_ready), 32'd2);
    chk("wr.c1_gnt", 32'(gnt), 32'd2);
    chk("wr.c1_we", 32'(mem_a_we), 0);
    tick(); req = 2'b00; wr_valid = 2'b00; #1;
    chk("wr.c2_ready", 32'(wr_ready), 0);
    chk("wr.c2_we", 32'(mem_a_we), 32'd1);
    chk("wr.c2_addr", 32'(mem_a_addr), 32'h020);
    chk("wr.c2_din", 32'(mem_a_din), 32'hA1);
    tick(); wr_valid = 2'b10; wr_data[15:8] = 8'hA2; #1;
    chk("wr.c3_ready", 32'(wr_ready), 32'd2);
    chk("wr.c3_we", 32'(mem_a_we), 0);
    tick(); wr_data[15:8] = 8'hA3; #1;
    chk("wr.c4_we", 32'(mem_a_we), 32'd1);
    chk("wr.c4_addr", 32'(mem_a_addr), 32'h021);
    chk("wr.c4_din", 32'(mem_a_din), 32'hA2);
    chk("wr.c4_done", 32'(done), 0);
    tick(); wr_valid = 2'b00; #1;
    chk("wr.done", 32'(done), 32'd2);
    chk("wr.c5_addr", 32'(mem_a_addr), 32'h022);
    chk("wr.c5_din", 32'(mem_a_din), 32'hA3);
    chk("wr.rd_en", 32'(mem_rd_en), 0);
    tick(); #1;
    chk_quiet("wr.after");

    // Read the written data back through requester 1.
    tick(); req = 2'b10; req_wr = 2'b00; #1;
    for (int k = 0; k < 4; k++) begin
      tick(); if (k == 0) req = 2'b00; #1;
      chk("rb.gnt", 32'(gnt), 32'd2);
      if (k < 3) chk("rb.addr", 32'(mem_rd_addr), 32'h020 + 32'(k));
      if (k > 0) begin
        chk("rb.valid", 32'(rd_valid), 32'd2);
        chk("rb.data", 32'(rd_data), 32'(wexp[k-1]));
      end
    end
    tick(); #1;
    chk("rb.done", 32'(done), 32'd2);

    // Zero-length read and write: no memory access, done on the cycle after the grant.
    tick(); req = 2'b01; req_len[7:0] = 8'd0; #1;
    tick(); req = 2'b00; #1;
    chk("z0.done", 32'(done), 32'd1);
    chk("z0.busy", 32'(busy), 32'd1);
    chk("z0.rd_en", 32'(mem_rd_en), 0);
    tick(); #1;
    chk_quiet("z0.after");
    tick(); req = 2'b10; req_wr = 2'b10; req_len[15:8] = 8'd0; wr_valid = 2'b10; #1;
    tick(); req = 2'b00; #1;
    chk("z1.done", 32'(done), 32'd2);
    chk("z1.ready", 32'(wr_ready), 0);
    chk("z1.we", 32'(mem_a_we), 0);
    tick(); wr_valid = 2'b00; req_wr = 2'b00; #1;
    chk_quiet("z1.after");

    // Address wrap: base 0x3FE, length 4.
    tick(); req = 2'b01; req_base[9:0] = 10'h3FE; req_len[7:0] = 8'd4; #1;
    for (int k = 0; k < 5; k++) begin
      tick(); if (k == 0) req = 2'b00; #1;
      if (k < 4) chk("wrap.addr", 32'(mem_rd_addr), 32'(wrap_a[k]));
      if (k > 0) chk("wrap.data", 32'(rd_data), 32'(wrap_d[k-1]));
    end
    tick(); #1;
    chk("wrap.done", 32'(done), 32'd1);

    // Abort during the 3rd beat of a 10-beat read.
    tick(); req = 2'b01; req_base[9:0] = 10'h000; req_len[7:0] = 8'd10; #1;
    tick(); req = 2'b00; #1;
    chk("ab.gnt", 32'(gnt), 32'd1);
    tick(); #1;
    tick(); abort = 1'b1; #1;
    chk("ab.c3_addr", 32'(mem_rd_addr), 32'h002);
    chk("ab.c3_done", 32'(done), 0);
    tick(); abort = 1'b0; #1;
    chk_quiet("ab.c4");
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("ab.no_done", 32'(done), 0);
      chk("ab.idle", 32'(busy), 0);
    end
    tick(); req = 2'b01; req_base[9:0] = 10'h010; req_len[7:0] = 8'd2; #1;
    tick(); req = 2'b00; #1;
    chk("ab2.gnt", 32'(gnt), 32'd1);
    chk("ab2.addr", 32'(mem_rd_addr), 32'h010);
    tick(); #1;
    chk("ab2.data0", 32'(rd_data), 32'd5);
    tick(); #1;
    chk("ab2.data1", 32'(rd_data), 32'd6);
    chk("ab2.index1", 32'(rd_index), 32'd1);
    tick(); #1;
    chk("ab2.done", 32'(done), 32'd1);

    // Tie from reset: requester 0, then 1, then 0 again.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); req = 2'b11; req_wr = 2'b00; req_base = {10'h020, 10'h010}; req_len = {8'd2, 8'd2}; #1;
    for (int c = 1; c <= 15; c++) begin
      tick(); if (c == 11) req = 2'b00; #1;
      if (c == 1)  chk("tie.gnt_c1", 32'(gnt), 32'd1);
      if (c == 4)  chk("tie.done0", 32'(done), 32'd1);
      if (c == 5)  chk("tie.gap", 32'(gnt), 32'd0);
      if (c == 6)  chk("tie.gnt_c6", 32'(gnt), 32'd2);
      if (c == 7)  chk("tie.rv1", 32'(rd_valid), 32'd2);
      if (c == 7)  chk("tie.rd1", 32'(rd_data), 32'h55);
      if (c == 9)  chk("tie.done1", 32'(done), 32'd2);
      if (c == 11) chk("tie.gnt_c11", 32'(gnt), 32'd1);
      if (c == 14) chk("tie.done0b", 32'(done), 32'd1);
      if (c == 15) chk("tie.idle", 32'(busy), 32'd0);
    end

    // Reset asserted mid-burst.
    tick(); req = 2'b01; req_len[7:0] = 8'd4; #1;
    tick(); req = 2'b00; #1;
    tick(); rst_n = 1'b0; #1;
    chk_quiet("mrst");
    chk("mrst.rd_valid", 32'(rd_valid), 0);
    tick(); rst_n = 1'b1;
    tick(); #1;
    chk_quiet("mrst.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
